// File: rtl/tour_pkg.sv
// Shared constants and types for the tour command sequencer.
package tour_pkg;

    localparam int NUM_MOVES = 24;

    localparam logic [7:0] RESP_MORE = 8'hA5;
    localparam logic [7:0] RESP_DONE = 8'h5A;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLD_V,
        HORZ,
        HOLD_H
    } state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] heading;
        logic [3:0] squares;
    } cmd_t;

    function automatic cmd_t make_cmd(input logic [3:0] op, input logic [7:0] hdg,
                                      input logic [3:0] sq);
        cmd_t c;
        c.opcode  = op;
        c.heading = hdg;
        c.squares = sq;
        return c;
    endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Command/response bus between the UART wrapper, the tour sequencer and
// the command processor.
interface tour_cmd_if;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    // Environment side: supplies UART commands and command-processor handshakes
    modport master (
        output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  cmd, cmd_rdy, resp
    );

    // Sequencer side
    modport slave (
        input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output cmd, cmd_rdy, resp
    );
endinterface

// File: rtl/tour_move_decode.sv
// Splits a one-hot knight move into a vertical leg and a fanfare horizontal leg.
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    // Isolating the lowest set bit makes a multi-hot move resolve to its lowest move
    logic [7:0] lowest;
    logic [7:0] v_hdg;
    logic [3:0] v_sq;
    logic [7:0] h_hdg;
    logic [3:0] h_sq;

    assign lowest = move & (~move + 8'd1);

    // Map each move to heading and distance for both legs; no move gives zero-length N/E legs
    always_comb begin
        v_hdg = HDG_N;
        v_sq  = 4'd0;
        h_hdg = HDG_E;
        h_sq  = 4'd0;
        case (lowest)
            8'h01: begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end
            8'h02: begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end
            8'h04: begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end
            8'h08: begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end
            8'h10: begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end
            8'h20: begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end
            8'h40: begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end
            8'h80: begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end
            default: ;
        endcase
    end

    assign vert_cmd = make_cmd(OP_MOVE, v_hdg, v_sq);
    assign horz_cmd = make_cmd(OP_FANFARE, h_hdg, h_sq);

endmodule

// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as robot commands, muxed with UART commands.
module tour_cmd
    import tour_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_tour,
    input  logic [7:0] move,
    output logic [4:0] mv_indx,
    tour_cmd_if.slave  bus
);

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    state_t      state_reg, state_next;
    logic [4:0]  mv_indx_reg, mv_indx_next;
    logic [15:0] vert_cmd, horz_cmd;
    logic        last_move;

    tour_move_decode u_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    assign last_move = (mv_indx_reg == LAST_INDX);
    assign mv_indx   = mv_indx_reg;

    // State and move index registers; reset aborts any tour in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            mv_indx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mv_indx_reg <= mv_indx_next;
        end
    end

    // Leg sequencing; the index only advances between knight moves so move stays stable
    always_comb begin
        state_next   = state_reg;
        mv_indx_next = mv_indx_reg;
        case (state_reg)
            IDLE: begin
                if (start_tour) begin
                    state_next   = VERT;
                    mv_indx_next = '0;
                end
            end
            VERT:   if (bus.clr_cmd_rdy) state_next = HOLD_V;
            HOLD_V: if (bus.send_resp)   state_next = HORZ;
            HORZ:   if (bus.clr_cmd_rdy) state_next = HOLD_H;
            HOLD_H: begin
                if (bus.send_resp) begin
                    if (last_move) begin
                        state_next   = IDLE;
                        mv_indx_next = '0;
                    end else begin
                        state_next   = VERT;
                        mv_indx_next = mv_indx_reg + 5'd1;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                mv_indx_next = '0;
            end
        endcase
    end

    // Command mux and response byte; UART owns the command path only while idle
    always_comb begin
        bus.cmd     = bus.cmd_UART;
        bus.cmd_rdy = bus.cmd_rdy_UART;
        bus.resp    = RESP_MORE;
        case (state_reg)
            IDLE: bus.resp = RESP_DONE;
            VERT: begin
                bus.cmd     = vert_cmd;
                bus.cmd_rdy = 1'b1;
            end
            HOLD_V: begin
                bus.cmd     = vert_cmd;
                bus.cmd_rdy = 1'b0;
            end
            HORZ: begin
                bus.cmd     = horz_cmd;
                bus.cmd_rdy = 1'b1;
            end
            HOLD_H: begin
                bus.cmd     = horz_cmd;
                bus.cmd_rdy = 1'b0;
                bus.resp    = last_move ? RESP_DONE : RESP_MORE;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Scoreboard bench: stimulus queues expected commands/responses, a monitor checks them.
module tb_tour_cmd;

    logic       clk;
    logic       rst_n;
    logic       start_tour;
    logic [7:0] move;
    logic [4:0] mv_indx;

    tour_cmd_if bus_if ();

    tour_cmd dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_tour (start_tour),
        .move       (move),
        .mv_indx    (mv_indx),
        .bus        (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Solver model: move table addressed by mv_indx
    localparam logic [7:0] TOUR_MOVE [24] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h0C, 8'hA0, 8'h00, 8'h81, 8'h10, 8'h40, 8'h02, 8'h08,
        8'h20, 8'h80, 8'h04, 8'h01, 8'h30, 8'hC0, 8'h06, 8'h08
    };
    // Hand-computed legs for each table entry
    localparam logic [15:0] VERT_EXP [24] = '{
        16'h2002, 16'h2002, 16'h2001, 16'h27F1, 16'h27F2, 16'h27F2, 16'h27F1, 16'h2001,
        16'h2001, 16'h27F2, 16'h2000, 16'h2002, 16'h27F2, 16'h27F1, 16'h2002, 16'h27F1,
        16'h27F2, 16'h2001, 16'h2001, 16'h2002, 16'h27F2, 16'h27F1, 16'h2002, 16'h27F1
    };
    localparam logic [15:0] HORZ_EXP [24] = '{
        16'h3BF1, 16'h33F1, 16'h33F2, 16'h33F2, 16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2,
        16'h33F2, 16'h3BF1, 16'h3BF0, 16'h3BF1, 16'h33F1, 16'h3BF2, 16'h33F1, 16'h33F2,
        16'h3BF1, 16'h3BF2, 16'h33F2, 16'h3BF1, 16'h33F1, 16'h3BF2, 16'h33F1, 16'h33F2
    };

    assign move = (mv_indx < 5'd24) ? TOUR_MOVE[mv_indx] : 8'h00;

    typedef struct packed {
        logic [15:0] cmd;
        logic [4:0]  indx;
    } exp_t;

    exp_t       cmd_q [$];
    logic [7:0] resp_q [$];
    int         checks   = 0;
    int         errors   = 0;
    int         rise_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cmd_rdy rising edge and every send_resp cycle consumes one expectation
    initial begin
        logic prev_rdy;
        exp_t e;
        logic [7:0] r;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.cmd_rdy && !prev_rdy) begin
                rise_cnt++;
                checks++;
                if (cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected: got cmd %04h with no expectation queued",
                             bus_if.cmd);
                end else begin
                    e = cmd_q.pop_front();
                    $display("cmd txn: cmd=%04h mv_indx=%0d (exp %04h / %0d)",
                             bus_if.cmd, mv_indx, e.cmd, e.indx);
                    if (bus_if.cmd !== e.cmd) begin
                        errors++;
                        $display("FAIL cmd: got %04h expected %04h", bus_if.cmd, e.cmd);
                    end
                    check("cmd_mv_indx", 32'(mv_indx), 32'(e.indx));
                end
            end
            if (bus_if.send_resp) begin
                checks++;
                if (resp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got %02h with no expectation queued",
                             bus_if.resp);
                end else begin
                    r = resp_q.pop_front();
                    $display("resp txn: resp=%02h (exp %02h)", bus_if.resp, r);
                    if (bus_if.resp !== r) begin
                        errors++;
                        $display("FAIL resp: got %02h expected %02h", bus_if.resp, r);
                    end
                end
            end
            prev_rdy = bus_if.cmd_rdy;
        end
    end

    task automatic wait_rdy(input string name);
        int n;
        n = 0;
        while (bus_if.cmd_rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s: cmd_rdy timeout got 0 expected 1", name);
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 bus_if.clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 bus_if.clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_send(input logic [7:0] exp_resp);
        @(posedge clk); #1;
        resp_q.push_back(exp_resp);
        bus_if.send_resp = 1'b1;
        @(posedge clk); #1 bus_if.send_resp = 1'b0;
    endtask

    // mode: 0 normal, 1 clr+send together in VERT, 2 disturb with start/UART, 3 reset in HOLD_H
    task automatic knight(input int i, input bit first, input bit last, input int mode);
        cmd_q.push_back('{cmd: VERT_EXP[i], indx: 5'(i)});
        cmd_q.push_back('{cmd: HORZ_EXP[i], indx: 5'(i)});
        if (first) begin
            @(posedge clk); #1 start_tour = 1'b1;
            @(posedge clk); #1 start_tour = 1'b0;
            @(negedge clk);
            check("start_latency_rdy", 32'(bus_if.cmd_rdy), 32'd1);
        end
        wait_rdy("vert_rdy");
        if (mode == 1) begin
            @(posedge clk); #1;
            resp_q.push_back(8'hA5);
            bus_if.clr_cmd_rdy = 1'b1;
            bus_if.send_resp   = 1'b1;
            @(posedge clk); #1;
            bus_if.clr_cmd_rdy = 1'b0;
            bus_if.send_resp   = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("both_in_vert_hold", 32'(bus_if.cmd_rdy), 32'd0);
            end
        end else begin
            pulse_clr();
        end
        @(negedge clk);
        check("hold_v_rdy", 32'(bus_if.cmd_rdy), 32'd0);
        check("hold_v_cmd", 32'(bus_if.cmd), 32'(VERT_EXP[i]));
        if (mode == 2) begin
            @(posedge clk); #1 start_tour = 1'b1;
            @(posedge clk); #1 start_tour = 1'b0;
            @(negedge clk);
            check("no_restart_rdy", 32'(bus_if.cmd_rdy), 32'd0);
            check("no_restart_indx", 32'(mv_indx), 32'(i));
        end
        pulse_send(8'hA5);
        wait_rdy("horz_rdy");
        if (mode == 2) begin
            @(posedge clk); #1;
            bus_if.cmd_UART     = 16'hABCD;
            bus_if.cmd_rdy_UART = 1'b1;
            @(posedge clk); #1 bus_if.cmd_rdy_UART = 1'b0;
            @(negedge clk);
            check("uart_ignored_cmd", 32'(bus_if.cmd), 32'(HORZ_EXP[i]));
            check("uart_ignored_rdy", 32'(bus_if.cmd_rdy), 32'd1);
            check("uart_ignored_indx", 32'(mv_indx), 32'(i));
        end
        pulse_clr();
        @(negedge clk);
        check("hold_h_rdy", 32'(bus_if.cmd_rdy), 32'd0);
        check("hold_h_resp", 32'(bus_if.resp), last ? 32'h5A : 32'hA5);
        if (mode == 3) begin
            #2 rst_n = 1'b0;
            #1;
            check("abort_indx", 32'(mv_indx), 32'd0);
            check("abort_cmd", 32'(bus_if.cmd), 32'(bus_if.cmd_UART));
            check("abort_rdy", 32'(bus_if.cmd_rdy), 32'd0);
            check("abort_resp", 32'(bus_if.resp), 32'h5A);
            @(posedge clk); #1 rst_n = 1'b1;
        end else begin
            pulse_send(last ? 8'h5A : 8'hA5);
        end
    endtask

    initial begin
        int rise0;
        rst_n               = 1'b0;
        start_tour          = 1'b0;
        bus_if.cmd_UART     = 16'h1234;
        bus_if.cmd_rdy_UART = 1'b0;
        bus_if.clr_cmd_rdy  = 1'b0;
        bus_if.send_resp    = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_indx", 32'(mv_indx), 32'd0);
        check("reset_cmd", 32'(bus_if.cmd), 32'h1234);
        check("reset_rdy", 32'(bus_if.cmd_rdy), 32'd0);
        check("reset_resp", 32'(bus_if.resp), 32'h5A);
        @(posedge clk); #1 rst_n = 1'b1;

        // UART pass-through in IDLE
        @(posedge clk); #1;
        cmd_q.push_back('{cmd: 16'h2004, indx: 5'd0});
        bus_if.cmd_UART     = 16'h2004;
        bus_if.cmd_rdy_UART = 1'b1;
        @(negedge clk);
        check("uart_resp", 32'(bus_if.resp), 32'h5A);
        @(posedge clk); #1 bus_if.cmd_rdy_UART = 1'b0;
        pulse_send(8'h5A);

        // Full tour with ordering and interference cases embedded
        rise0 = rise_cnt;
        for (int i = 0; i < 24; i++)
            knight(i, i == 0, i == 23, (i == 3) ? 1 : ((i == 5) ? 2 : 0));
        @(negedge clk);
        check("tour_rises", 32'(rise_cnt - rise0), 32'd48);
        check("tour_end_indx", 32'(mv_indx), 32'd0);
        check("tour_end_resp", 32'(bus_if.resp), 32'h5A);
        check("tour_end_cmd", 32'(bus_if.cmd), 32'(bus_if.cmd_UART));

        // Second tour aborted by reset in HOLD_H at move 10
        @(posedge clk); #1 bus_if.cmd_UART = 16'h3455;
        for (int i = 0; i <= 10; i++)
            knight(i, i == 0, 1'b0, (i == 10) ? 3 : 0);
        @(negedge clk);
        check("post_abort_indx", 32'(mv_indx), 32'd0);
        check("post_abort_cmd", 32'(bus_if.cmd), 32'h3455);
        check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Downstream of the tour solver.
- Once the solver pulses completion, this block walks the 24 stored one-hot moves by driving the solver's move index, and splits each knight move into two robot commands:
  - a vertical leg first,
  - then a horizontal leg carrying the fanfare opcode.
- It muxes these commands with UART-originated commands, toward the command processor.
- It generates the response byte returned to the host after each leg.

Parameters:
- NUM_MOVES, 24, number of moves in a completed 5x5 tour.
- RESP_MORE, 8'hA5, response while tour legs remain.
- RESP_DONE, 8'h5A, response for the final leg and for UART-mode commands.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_tour  in  1  one-cycle pulse from solver: solution ready
- move  in  8  one-hot move addressed by mv_indx (combinational from solver)
- mv_indx  out  5  index of move currently being executed
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- cmd  out  16  muxed command to command processor
- cmd_rdy  out  1  muxed command valid
- clr_cmd_rdy  in  1  command processor has taken cmd
- send_resp  in  1  command processor finished executing cmd
- resp  out  8  response byte to UART transmitter

Behaviour:
- Reset (async, rst_n low) forces:
  - state=IDLE, mv_indx=0.
  - Outputs follow IDLE mux: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=RESP_DONE.
- Command format:
  - [15:12] opcode: 4'h2 = move, 4'h3 = move with fanfare.
  - [11:4] heading: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
  - [3:0] squares.
- Move decode, bit -> (dx,dy):
  - 0: (+1,+2)
  - 1: (-1,+2)
  - 2: (-2,+1)
  - 3: (-2,-1)
  - 4: (-1,-2)
  - 5: (+1,-2)
  - 6: (+2,-1)
  - 7: (+2,+1)
- Leg construction:
  - Vertical leg: opcode 4'h2; heading N if dy>0, else S; squares=|dy|.
  - Horizontal leg: opcode 4'h3; heading E if dx>0, else W; squares=|dx|.
  - Lowest set bit wins if move is multi-hot.
  - move==0 yields both legs with squares=0, heading N/E; no error flag.
- States: IDLE, VERT, HOLD_V, HORZ, HOLD_H. cmd/cmd_rdy are muxed to the tour side in every state except IDLE.
- IDLE:
  - UART pass-through.
  - start_tour -> VERT, mv_indx<=0.
  - cmd_rdy_UART is ignored once the tour starts.
- VERT:
  - cmd = vertical leg of move, cmd_rdy=1.
  - clr_cmd_rdy -> HOLD_V.
- HOLD_V:
  - cmd held, cmd_rdy=0.
  - send_resp -> HORZ.
- HORZ:
  - cmd = horizontal leg, cmd_rdy=1.
  - clr_cmd_rdy -> HOLD_H.
- HOLD_H:
  - cmd held, cmd_rdy=0.
  - On send_resp: if mv_indx==NUM_MOVES-1 -> IDLE and mv_indx<=0; else mv_indx<=mv_indx+1 -> VERT.
- resp:
  - In IDLE: RESP_DONE.
  - In HOLD_H with mv_indx==NUM_MOVES-1: RESP_DONE.
  - In every other tour state: RESP_MORE.
  - resp is combinational on state/mv_indx and valid in the send_resp cycle.
- mv_indx:
  - Changes only on the HOLD_H->VERT edge, so move is stable for a whole knight move.
  - Never exceeds 23; no wrap beyond.
- start_tour outside IDLE is ignored; a tour cannot be restarted mid-run.
- Ordering:
  - clr_cmd_rdy and send_resp asserted in the same cycle in VERT: only clr_cmd_rdy is acted on; send_resp is ignored (must arrive in HOLD_x).
  - send_resp in VERT/HORZ is ignored.
- Reset mid-tour aborts immediately to IDLE with mv_indx=0. There is no resume.
- Latency: 1 cycle from start_tour to cmd_rdy=1 with the first vertical leg.

Decomposition:
- Package tour_pkg holds:
  - opcode constants (OP_MOVE, OP_FANFARE),
  - heading constants (HDG_N/W/S/E),
  - RESP_MORE/RESP_DONE,
  - state enum typedef,
  - 16-bit cmd_t packed struct.
- Sub-module tour_move_decode is purely combinational: move[7:0] -> vert_cmd[15:0], horz_cmd[15:0].

Test Plan:
- Reset, then cmd_UART=16'h2004 with cmd_rdy_UART=1 -> cmd=16'h2004, cmd_rdy=1, resp=8'h5A.
- start_tour with move=8'h01 -> next cycle cmd=16'h2002, cmd_rdy=1. After clr_cmd_rdy: cmd_rdy=0. After send_resp: resp=8'hA5, cmd=16'h3BF1.
- move=8'h08 -> vertical 16'h27F1, horizontal 16'h33F2. move=8'h40 -> 16'h27F1 then 16'h3BF2.
- Full tour with a fixed 24-entry move table:
  - mv_indx steps 0..23;
  - exactly 48 cmd_rdy rising edges;
  - resp=8'hA5 on the first 47 send_resp and 8'h5A on the 48th;
  - return to IDLE with mv_indx=0.
- Assert start_tour during HOLD_V and cmd_rdy_UART during HORZ -> no state or mv_indx change; cmd is still the tour leg.
- Drop rst_n during HOLD_H at mv_indx=10 -> state IDLE and mv_indx=0 asynchronously; cmd follows cmd_UART.
